// File: rtl/serial_rx_pkg.sv
// -----------------------------------------------------------------------------
// serial_rx_pkg
// Shared definitions for the serial byte receiver: FSM state encoding, data
// width, idle line level and the even-parity helper.
// -----------------------------------------------------------------------------
package serial_rx_pkg;

   localparam int   DATA_BITS     = 8;
   localparam logic RX_IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } rx_state_t;

   // Even parity holds when data bits plus parity bit contain an even number of ones.
   function automatic logic even_parity_ok(input logic [DATA_BITS-1:0] data,
                                           input logic                 par);
      return (((^data) ^ par) == 1'b0);
   endfunction

endpackage

// File: rtl/serial_byte_receiver_if.sv
// -----------------------------------------------------------------------------
// serial_byte_receiver_if
// Bundles the serial line and the parallel result bus of serial_byte_receiver.
//   rx        : serial line, idles high, asynchronous to clk
//   data_out  : last correctly received byte (held)
//   valid     : one-cycle pulse, data_out updated this cycle
//   busy      : frame in progress
//   frame_err : one-cycle pulse, frame rejected
// Modports: master = line driver / byte consumer, slave = receiver.
// -----------------------------------------------------------------------------
interface serial_byte_receiver_if;
   import serial_rx_pkg::*;

   logic                 rx;
   logic [DATA_BITS-1:0] data_out;
   logic                 valid;
   logic                 busy;
   logic                 frame_err;

   modport master (output rx, input data_out, input valid, input busy, input frame_err);
   modport slave  (input rx, output data_out, output valid, output busy, output frame_err);

endinterface

// File: rtl/bit_synchronizer.sv
// -----------------------------------------------------------------------------
// bit_synchronizer
// Two-flop synchronizer for a single asynchronous input bit.
//   clk       : destination clock, rising edge
//   rst       : asynchronous, active-low reset; both flops load RESET_VAL
//   i_d       : asynchronous input
//   o_q       : synchronized output
// Parameter RESET_VAL should match the idle level of the input so that reset
// release does not look like an edge.
// -----------------------------------------------------------------------------
module bit_synchronizer #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   // Two-stage capture of the asynchronous input.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/serial_byte_receiver.sv
// -----------------------------------------------------------------------------
// serial_byte_receiver
// UART-style receiver: start bit, 8 data bits LSB first, optional even parity,
// stop bit. The assembled byte is presented as a held output that only changes
// on a good frame.
//   clk  : sole clock, rising edge
//   rst  : asynchronous, active-low reset
//   bus  : serial_byte_receiver_if.slave (rx in; data_out, valid, busy,
//          frame_err out, all registered)
// Parameter CLKS_PER_BIT: clocks per serial bit, even and >= 4.
// Build option SERIAL_RX_PARITY_EN: when defined, an even-parity bit follows
// the data bits and a parity mismatch rejects the frame.
// -----------------------------------------------------------------------------
module serial_byte_receiver
   import serial_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   serial_byte_receiver_if.slave  bus
);

   localparam int HALF_BIT = CLKS_PER_BIT / 2;
   localparam int CW       = $clog2(CLKS_PER_BIT);
   localparam int IW       = $clog2(DATA_BITS);

   localparam logic [CW-1:0] CNT_HALF_LAST = CW'(HALF_BIT - 1);
   localparam logic [CW-1:0] CNT_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_ONE       = CW'(1);
   localparam logic [IW-1:0] IDX_LAST      = IW'(DATA_BITS - 1);
   localparam logic [IW-1:0] IDX_ONE       = IW'(1);

   logic                 w_rx_s;
   logic                 w_par_ok;
   rx_state_t            r_state;
   logic [CW-1:0]        r_cnt;
   logic [IW-1:0]        r_idx;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] r_data;
   logic                 r_valid;
   logic                 r_frame_err;
   logic                 r_busy;

   // Preset to the idle level so reset release is not mistaken for a start edge.
   bit_synchronizer #(
      .RESET_VAL (RX_IDLE_LEVEL)
   ) u_rx_sync (
      .clk (clk),
      .rst (rst),
      .i_d (bus.rx),
      .o_q (w_rx_s)
   );

`ifdef SERIAL_RX_PARITY_EN
   logic r_par;
   assign w_par_ok = even_parity_ok(r_shift, r_par);
`else
   assign w_par_ok = 1'b1;
`endif

   // Frame FSM: counters, shift register and all registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_shift     <= '0;
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         r_busy      <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
         r_par       <= 1'b0;
`endif
      end else begin
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_cnt <= '0;
               if (w_rx_s != RX_IDLE_LEVEL) begin
                  r_state <= ST_START;
                  r_busy  <= 1'b1;
               end else begin
                  r_busy  <= 1'b0;
               end
            end
            ST_START: begin
               // Mid-bit recheck: a line already back high was only a glitch.
               if (r_cnt == CNT_HALF_LAST) begin
                  r_cnt <= '0;
                  r_idx <= '0;
                  if (w_rx_s != RX_IDLE_LEVEL) begin
                     r_state <= ST_DATA;
                  end else begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            ST_DATA: begin
               if (r_cnt == CNT_BIT_LAST) begin
                  r_cnt          <= '0;
                  r_shift[r_idx] <= w_rx_s;
                  if (r_idx == IDX_LAST) begin
                     r_idx   <= '0;
`ifdef SERIAL_RX_PARITY_EN
                     r_state <= ST_PARITY;
`else
                     r_state <= ST_STOP;
`endif
                  end else begin
                     r_idx <= r_idx + IDX_ONE;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
`ifdef SERIAL_RX_PARITY_EN
            ST_PARITY: begin
               if (r_cnt == CNT_BIT_LAST) begin
                  r_cnt   <= '0;
                  r_par   <= w_rx_s;
                  r_state <= ST_STOP;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
`endif
            ST_STOP: begin
               if (r_cnt == CNT_BIT_LAST) begin
                  r_cnt   <= '0;
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  // data_out is only ever loaded here, so a rejected frame leaves it held.
                  if ((w_rx_s == RX_IDLE_LEVEL) && w_par_ok) begin
                     r_data  <= r_shift;
                     r_valid <= 1'b1;
                  end else begin
                     r_frame_err <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.data_out  = r_data;
   assign bus.valid     = r_valid;
   assign bus.busy      = r_busy;
   assign bus.frame_err = r_frame_err;

endmodule

// File: doc/serial_byte_receiver.md
# serial_byte_receiver

Upstream stage for the 8-bit register bank: receives an asynchronous, UART-style serial line (start bit, 8 data bits LSB-first, optional parity, stop bit) and presents the assembled byte on a parallel bus. The register bank captures on every clock, so `data_out` is a held output: it changes only on a good frame and stays stable between frames. `valid` marks the single cycle in which a new byte appears.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; even, ≥ 4.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `rx` input 1: serial line, idles high, asynchronous to `clk`.
- `data_out` output 8: last correctly received byte; feeds the register bank `in`.
- `valid` output 1: one-cycle pulse, `data_out` updated this cycle.
- `busy` output 1: high while a frame is in progress (any state except IDLE).
- `frame_err` output 1: one-cycle pulse; the frame was rejected (bad stop bit, or bad parity when enabled).

## Operation
- All outputs reset to 0 while `rst` = 0. Reset clears the state to IDLE, clears the counters and the shift register, and presets the synchronizer to 1.
- `rx` passes through a 2-flop synchronizer; the FSM uses only the synchronized value `rx_s`.
- Let N = `CLKS_PER_BIT` and H = N/2. The bit counter `cnt` runs from 0 to N−1. The bit index runs from 0 to 7.
- FSM states:
  - IDLE: if `rx_s` = 0, go to START and set `cnt` = 0.
  - START: at `cnt` = H−1, sample `rx_s`. If 0, go to DATA with `cnt` = 0 and index = 0. If 1, treat it as a glitch and return to IDLE with no error.
  - DATA: at `cnt` = N−1, shift `rx_s` into bit[index] (LSB first). After bit 7, go to PARITY if enabled, otherwise to STOP.
  - PARITY (only when the macro is enabled): at `cnt` = N−1, sample the parity bit. Even parity is required: XOR of the 8 data bits and the parity bit must equal 0.
  - STOP: at `cnt` = N−1, sample `rx_s`.
    - Good frame (stop = 1 and parity OK): load `data_out` from the shift register, pulse `valid`, go to IDLE.
    - Otherwise: pulse `frame_err`, leave `data_out` unchanged, go to IDLE.
- `valid` and `frame_err` are never high in the same cycle.
- A frame whose stop bit is low returns to IDLE, then restarts immediately if `rx_s` is still low (break condition). The result is repeated `frame_err` pulses, one per frame length.
- Reset asserted mid-frame aborts the frame immediately. No `valid` or `frame_err` is produced, and `data_out` reads 0.
- Back-to-back frames are supported: IDLE can accept a new start edge on the cycle after STOP.

## Timing
- Edge numbering: `rx` falls before rising edge 0.
  - The FSM enters START at edge 2 (2-flop synchronizer latency).
  - The START sample is taken at edge 2+H.
  - Data bit i is sampled at edge 2+H+(i+1)·N.
- Without parity, the stop sample is at edge 2+H+9N. `data_out`, `valid` and `frame_err` are registered at that edge. For N = 16 this is edge 154.
- With parity, the stop sample is at edge 2+H+10N (edge 170 for N = 16).
- `busy` is high from edge 2 up to the result edge. It is low in the cycle in which `valid` or `frame_err` is high.
- `data_out` is stable in every cycle except the one following a good-frame edge.

## Configuration
- `SERIAL_RX_PARITY_EN`
  - Defined: the PARITY state exists, the frame is 11 bits, and a parity mismatch produces `frame_err` with `data_out` held.
  - Undefined: no PARITY state, no parity logic, 10-bit frame; only the stop bit is checked.

## Structure
- Shared package `serial_rx_pkg`:
  - State enum (IDLE, START, DATA, PARITY, STOP).
  - `DATA_BITS` = 8.
  - `RX_IDLE_LEVEL` = 1.
- Sub-module `bit_synchronizer`: 2-flop synchronizer with `clk`, `rst`, and a reset value parameter (set to 1 for this block). Reused by other asynchronous inputs in the design.

## Test plan
- N = 16, frame 0xA5 with a good stop bit → `valid` = 1 for exactly one cycle at edge 154, `data_out` = 0xA5 and held afterwards, `frame_err` never high.
- `rx` low for 3 cycles, then high → back to IDLE after the START sample, `busy` low by edge 2+H+1, no `valid`, no `frame_err`.
- Frame 0x3C with the stop bit low, after a previous good byte 0x11 → one `frame_err` pulse, `data_out` stays 0x11.
- Back-to-back frames 0x00 then 0xFF with no idle gap → two `valid` pulses 10N cycles apart, `data_out` 0x00 then 0xFF.
- Reset asserted at the DATA bit-4 sample point of frame 0x5A → all outputs 0 immediately. After release, a clean frame 0x81 → `data_out` = 0x81.
- With `SERIAL_RX_PARITY_EN`: frame 0x07 with parity 1 → `valid` at edge 170. Same frame with parity 0 → `frame_err`, `data_out` held.
